// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared processor memory defaults and the read-owner state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int DEF_RAM_WIDTH     = 32;
    localparam int DEF_RAM_ADDR_BITS = 9;
    localparam int DEF_STARVE_LIMIT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/single_port_ram.sv
// ============================================================================
// Module  : single_port_ram
// Brief   : Single-port synchronous RAM, read-first, one cycle read latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module single_port_ram
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_i,
    input  logic [RAM_WIDTH-1:0]     wdata_i,
    output logic [RAM_WIDTH-1:0]     rdata_o
);

    logic [RAM_WIDTH-1:0] mem_q [0:(2**RAM_ADDR_BITS)-1];
    logic [RAM_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Arbitrates instruction-fetch and load/store ports onto one RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [RAM_ADDR_BITS-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [RAM_WIDTH-1:0]     if_rdata,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [RAM_ADDR_BITS-1:0] dm_addr,
    input  logic [RAM_WIDTH-1:0]     dm_wdata,
    output logic                     dm_gnt,
    output logic                     dm_rvalid,
    output logic [RAM_WIDTH-1:0]     dm_rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);

    localparam int               CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    rd_state_e            state_q, state_d;
    logic [CNT_W-1:0]     starv_q, starv_d;
    logic                 if_rvalid_q, dm_rvalid_q;
    logic [RAM_WIDTH-1:0] if_rdata_q, dm_rdata_q;
    logic                 starved;

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        starved = (starv_q == LIMIT);
        if_gnt  = ~reset & if_req & (~dm_req | starved);
        dm_gnt  = ~reset & dm_req & ~(if_req & starved);

        ram_en    = if_gnt | dm_gnt;
        ram_we    = dm_gnt & dm_we;
        ram_wdata = dm_gnt ? dm_wdata : '0;
        if (if_gnt) begin
            ram_addr = if_addr;
        end else if (dm_gnt) begin
            ram_addr = dm_addr;
        end else begin
            ram_addr = '0;
        end

        if (if_gnt || !if_req) begin
            starv_d = '0;
        end else if (dm_gnt && !starved) begin
            starv_d = starv_q + 1'b1;
        end else begin
            starv_d = starv_q;
        end

        if (if_gnt) begin
            state_d = RD_IF;
        end else if (dm_gnt && !dm_we) begin
            state_d = RD_DM;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            starv_q     <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starv_q     <= starv_d;
            if_rvalid_q <= (state_d == RD_IF);
            dm_rvalid_q <= (state_d == RD_DM);
            if (if_rvalid_q) begin
                if_rdata_q <= ram_rdata;
            end
            if (dm_rvalid_q) begin
                dm_rdata_q <= ram_rdata;
            end
        end
    end

    // Fresh RAM data is presented alongside rvalid, then held by the register.
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rvalid_q ? ram_rdata : if_rdata_q;
    assign dm_rdata  = dm_rvalid_q ? ram_rdata : dm_rdata_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32: data word width.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 9: word address width (512 words).
REQ-003 SHALL have parameter STARVE_LIMIT, default 2: consecutive data grants allowed while a fetch waits.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports if_req (in, 1), if_addr (in, RAM_ADDR_BITS), if_gnt (out, 1), if_rvalid (out, 1), if_rdata (out, RAM_WIDTH): the instruction-fetch read port.
REQ-007 SHALL have ports dm_req (in, 1), dm_we (in, 1), dm_addr (in, RAM_ADDR_BITS), dm_wdata (in, RAM_WIDTH), dm_gnt (out, 1), dm_rvalid (out, 1), dm_rdata (out, RAM_WIDTH): the load/store port.
REQ-008 SHALL have ports ram_en (out, 1), ram_we (out, 1), ram_addr (out, RAM_ADDR_BITS), ram_wdata (out, RAM_WIDTH) and ram_rdata (in, RAM_WIDTH): a single-port synchronous RAM with 1-cycle read latency.

Function
REQ-009 SHALL grant at most one port per cycle; the gnt outputs are combinational from the reqs and the registered state.
REQ-010 SHALL treat a request as accepted in the cycle where req=1 and gnt=1; the requester holds req, addr, we and wdata stable until that cycle.
REQ-011 SHALL, in the grant cycle, drive ram_en=1, ram_addr from the granted port, and ram_we=dm_we&dm_gnt; ram_wdata SHALL equal dm_wdata.
REQ-012 SHALL drive ram_en=0, ram_we=0, ram_addr=0 and ram_wdata=0 when no port is granted.
REQ-013 SHALL give priority to dm_req when both ports request, unless the starvation counter equals STARVE_LIMIT, in which case if_req is granted.
REQ-014 SHALL keep a starvation counter that increments on each dm grant while if_req=1, clears on any if grant or when if_req=0, and saturates at STARVE_LIMIT.
REQ-015 SHALL track the read owner with a registered FSM: IDLE -> RD_IF on an if grant, IDLE -> RD_DM on a dm read grant; from any state it moves to the owner of the current grant, or to IDLE if there is no read grant.
REQ-016 SHALL, for a dm write grant, not enter RD_DM and never assert dm_rvalid.
REQ-017 SHALL pulse if_rvalid (or dm_rvalid) for exactly one cycle, in the cycle after the grant, when the state is RD_IF (or RD_DM).
REQ-018 SHALL route ram_rdata to if_rdata or dm_rdata through a register loaded only on that port's rvalid cycle, holding the value until the port's next read returns.
REQ-019 SHALL sustain back-to-back grants: one access per cycle, with read latency of exactly 1 cycle from grant to rvalid.
REQ-020 SHALL ignore addr, we and wdata when the corresponding req=0.

Reset
REQ-021 SHALL, when reset=1, immediately force the FSM to IDLE, the starvation counter to 0, and if_rdata and dm_rdata to 0.
REQ-022 SHALL hold if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_en and ram_we at 0 while reset=1.
REQ-023 SHALL, if reset asserts the cycle after a read grant, drop that rvalid and deliver no data.
REQ-024 SHALL grant normally in the first cycle after reset deasserts.

Structure
REQ-025 SHALL take RAM_WIDTH, RAM_ADDR_BITS and the FSM state encoding (IDLE, RD_IF, RD_DM) from the shared processor package.
REQ-026 SHALL be a single module; the RAM itself stays outside the block, with one natural companion sub-module, single_port_ram, used in the bench and in the processor top.

Verification
REQ-027 SHALL cover: if_req=1, if_addr=5, RAM[5]=0xDEADBEEF -> if_gnt=1 in the same cycle, if_rvalid=1 the next cycle, if_rdata=0xDEADBEEF and held afterwards.
REQ-028 SHALL cover: dm_req=1, dm_we=1, dm_addr=7, dm_wdata=0x12345678, followed by a dm read of address 7 -> no rvalid for the write; the read returns 0x12345678.
REQ-029 SHALL cover: if_req and dm_req held at 1 continuously for 6 cycles -> grant order dm, dm, if, dm, dm, if.
REQ-030 SHALL cover: alternating reads if@0, dm@1, if@2 in consecutive cycles -> rvalid on the matching port in each following cycle, with no data crossing between ports.
REQ-031 SHALL cover: reset asserted asynchronously the cycle after an if grant -> if_rvalid stays 0, if_rdata=0, counter=0.
REQ-032 SHALL cover: if_req=0 and dm_req=0 -> ram_en=0 and both gnt=0 for every cycle.
